// File: rtl/hamming72_in.sv
// hamming72_in
//   SECDED Hamming(72,64) encoder and transmit controller feeding a 72-bit
//   SECDED decoder. Each accepted 64-bit word is encoded and transmitted with a
//   one-cycle sendin strobe. The codeword is then held stable until the
//   decoder reports delivery (dec_ready). A resend request or a timeout causes
//   a clean retransmission. After MAX_RETRY retransmissions the word is
//   dropped with a fail pulse. An optional error mask can be XORed onto the
//   first transmission only.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   data_valid/data_in    producer word, accepted when data_valid & data_ack
//   data_ack              high while idle and out of reset
//   inj_en/inj_mask       error mask applied to the first transmission
//   codeword_out/sendin   registered codeword and one-cycle transmit strobe
//   dec_ready/dec_resend  decoder delivery / uncorrectable-error response
//   done/fail             one-cycle pulses: delivered / dropped
//   retry_cnt             retransmissions used on the current word
//
// state | meaning
// IDLE  | ready for a new word, data_ack high
// SEND  | sendin strobe for the current codeword
// WAIT  | codeword held, waiting for ready/resend or timeout
module hamming72_in #(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 16,
    localparam int RW       = $clog2(MAX_RETRY + 1),
    localparam int TW       = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_valid,
    input  logic [63:0]   data_in,
    output logic          data_ack,
    input  logic          inj_en,
    input  logic [71:0]   inj_mask,
    output logic [71:0]   codeword_out,
    output logic          sendin,
    input  logic          dec_ready,
    input  logic          dec_resend,
    output logic          done,
    output logic          fail,
    output logic [RW-1:0] retry_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [71:0]   r_clean;
    logic [71:0]   r_cw;
    logic [RW-1:0] r_retry;
    logic [TW-1:0] r_tmo;
    logic          r_done;
    logic          r_fail;

    logic          w_accept;
    logic          w_send;
    logic          w_deliver;
    logic          w_drop;
    logic          w_retry;
    logic          w_tmo_hit;
    logic [71:0]   w_enc;
    logic [71:0]   w_mask;

    // Data bits fill the non-power-of-two positions in ascending order. Each
    // parity position 2^k covers every position with bit k of its index set;
    // parity positions themselves are still zero when the sums are formed, so
    // including them in the loop is harmless. Position 0 is overall parity.
    function automatic logic [71:0] f_encode(input logic [63:0] d);
        logic [71:0] cw;
        logic [6:0]  j;
        logic        p;
        cw = '0;
        j  = '0;
        for (int i = 1; i < 72; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i[6:0]] = d[j[5:0]];
                j          = j + 7'd1;
            end
        end
        for (int k = 0; k < 7; k++) begin
            p = 1'b0;
            for (int i = 1; i < 72; i++) begin
                if (((i >> k) & 1) != 0) begin
                    p = p ^ cw[i[6:0]];
                end
            end
            cw[7'(1 << k)] = p;
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    assign w_enc     = f_encode(data_in);
    assign w_mask    = inj_en ? inj_mask : '0;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_send    = 1'b0;
        w_deliver = 1'b0;
        w_drop    = 1'b0;
        w_retry   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SEND;
                end
            end
            S_SEND: begin
                w_send = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // ready wins over a simultaneous resend
                if (dec_ready) begin
                    w_deliver = 1'b1;
                    w_next    = S_IDLE;
                end else if (dec_resend || w_tmo_hit) begin
                    if (r_retry == RW'(MAX_RETRY)) begin
                        w_drop = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_retry = 1'b1;
                        w_next  = S_SEND;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The injected mask lives only in r_cw; a retry restores the clean copy,
    // which is what clears the mask for every retransmission.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clean <= '0;
            r_cw    <= '0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_done <= w_deliver;
            r_fail <= w_drop;
            if (w_accept) begin
                r_clean <= w_enc;
                r_cw    <= w_enc ^ w_mask;
                r_retry <= '0;
            end
            if (w_retry) begin
                r_cw    <= r_clean;
                r_retry <= r_retry + RW'(1);
            end
            if (w_send) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign data_ack     = (r_state == S_IDLE) & rst_n;
    assign sendin       = w_send;
    assign codeword_out = r_cw;
    assign done         = r_done;
    assign fail         = r_fail;
    assign retry_cnt    = r_retry;

endmodule

// File: tb/tb_hamming72_in.sv
module tb_hamming72_in;

    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;
    localparam int RW        = $clog2(MAX_RETRY + 1);

    localparam int M_DEC    = 0;
    localparam int M_RESEND = 1;
    localparam int M_SILENT = 2;

    localparam logic [71:0] CW_0    = 72'h00_0000_0000_0000_0000;
    localparam logic [71:0] CW_1    = 72'h00_0000_0000_0000_000F;
    localparam logic [71:0] CW_MSB  = 72'h81_0000_0000_0000_0017;
    localparam logic [71:0] CW_2    = 72'h00_0000_0000_0000_0033;
    localparam logic [71:0] CW_ONES = 72'hFF_FFFF_FFFF_FFFF_FFFF;

    logic          clk;
    logic          rst_n;
    logic          data_valid;
    logic [63:0]   data_in;
    logic          data_ack;
    logic          inj_en;
    logic [71:0]   inj_mask;
    logic [71:0]   codeword_out;
    logic          sendin;
    logic          dec_ready;
    logic          dec_resend;
    logic          done;
    logic          fail;
    logic [RW-1:0] retry_cnt;

    hamming72_in #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .data_ack     (data_ack),
        .inj_en       (inj_en),
        .inj_mask     (inj_mask),
        .codeword_out (codeword_out),
        .sendin       (sendin),
        .dec_ready    (dec_ready),
        .dec_resend   (dec_resend),
        .done         (done),
        .fail         (fail),
        .retry_cnt    (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] cw;
        int          rc;
    } tx_t;

    typedef struct {
        bit          is_fail;
        int          rc;
        bit          chk_data;
        logic [63:0] data;
    } end_t;

    tx_t         exp_tx[$];
    end_t        exp_end[$];
    int          errors = 0;
    int          checks = 0;
    int          mode = M_DEC;
    logic [63:0] dec_data = '0;

    task automatic push_tx(input logic [71:0] cw, input int rc);
        tx_t t;
        t.cw = cw;
        t.rc = rc;
        exp_tx.push_back(t);
    endtask

    task automatic push_end(input bit is_fail, input int rc, input bit chk, input logic [63:0] d);
        end_t e;
        e.is_fail  = is_fail;
        e.rc       = rc;
        e.chk_data = chk;
        e.data     = d;
        exp_end.push_back(e);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference SECDED decoder: syndrome plus overall parity.
    function automatic logic [6:0] f_syndrome(input logic [71:0] cw);
        logic [6:0] s;
        s = '0;
        for (int i = 1; i < 72; i++) begin
            if (cw[i]) s = s ^ 7'(i);
        end
        return s;
    endfunction

    function automatic logic [63:0] f_extract(input logic [71:0] cw);
        logic [63:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int i = 1; i < 72; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    // Decoder stub: samples the codeword in the cycle after sendin and
    // answers with a one-cycle ready/resend in that same cycle.
    initial begin : decoder
        bit          pend;
        logic [6:0]  s;
        logic [71:0] c;
        pend       = 1'b0;
        dec_ready  = 1'b0;
        dec_resend = 1'b0;
        forever begin
            @(negedge clk);
            dec_ready  = 1'b0;
            dec_resend = 1'b0;
            if (pend) begin
                pend = 1'b0;
                if (mode == M_DEC) begin
                    s = f_syndrome(codeword_out);
                    if (s != 7'd0 && (^codeword_out) == 1'b0) begin
                        dec_resend = 1'b1;
                    end else begin
                        c = codeword_out;
                        if (^codeword_out) c[s] = ~c[s];
                        dec_data  = f_extract(c);
                        dec_ready = 1'b1;
                    end
                end else if (mode == M_RESEND) begin
                    dec_resend = 1'b1;
                end
            end
            if (sendin && rst_n) pend = 1'b1;
        end
    end

    initial begin : monitor
        int   cyc;
        int   last_send;
        tx_t  t;
        end_t e;
        cyc       = 0;
        last_send = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sendin) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sendin: cw=%0h", codeword_out);
                end else begin
                    t = exp_tx.pop_front();
                    check("tx_codeword", 128'(codeword_out), 128'(t.cw));
                    check("tx_retry_cnt", 128'(retry_cnt), 128'(t.rc));
                    if (t.rc > 0 && mode == M_SILENT)
                        check("timeout_gap", 128'(cyc - last_send), 128'(TIMEOUT + 1));
                    if (t.rc > 0 && mode == M_RESEND)
                        check("resend_gap", 128'(cyc - last_send), 128'(2));
                end
                last_send = cyc;
            end
            if (done || fail) begin
                if (exp_end.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: done=%0b fail=%0b", done, fail);
                end else begin
                    e = exp_end.pop_front();
                    check("end_done", 128'(done), 128'(!e.is_fail));
                    check("end_fail", 128'(fail), 128'(e.is_fail));
                    check("end_retry_cnt", 128'(retry_cnt), 128'(e.rc));
                    if (e.chk_data) begin
                        check("done_after_ready", 128'(dec_ready), 128'(1));
                        check("decoded_data", 128'(dec_data), 128'(e.data));
                    end
                end
            end
        end
    end

    task automatic issue_word(input logic [63:0] d, input bit ie, input logic [71:0] m, input int md);
        @(negedge clk);
        mode       = md;
        data_in    = d;
        inj_en     = ie;
        inj_mask   = m;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        inj_en     = 1'b0;
        inj_mask   = '0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while ((exp_end.size() != 0 || exp_tx.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pending tx=%0d end=%0d, required 0", name, exp_tx.size(), exp_end.size());
            exp_tx.delete();
            exp_end.delete();
        end
    endtask

    task automatic run_word(input string name, input logic [63:0] d, input bit ie,
                            input logic [71:0] m, input int md);
        issue_word(d, ie, m, md);
        wait_end(name);
    endtask

    initial begin : stimulus
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        inj_en     = 1'b0;
        inj_mask   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_codeword", 128'(codeword_out), 128'(0));
        check("rst_sendin", 128'(sendin), 128'(0));
        check("rst_done_fail", 128'({done, fail}), 128'(0));
        check("rst_retry_cnt", 128'(retry_cnt), 128'(0));
        check("rst_ack_gated", 128'(data_ack), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ack", 128'(data_ack), 128'(1));

        push_tx(CW_0, 0);    push_end(0, 0, 1, 64'h0);
        run_word("zero", 64'h0, 0, '0, M_DEC);
        push_tx(CW_1, 0);    push_end(0, 0, 1, 64'h1);
        run_word("one", 64'h1, 0, '0, M_DEC);
        push_tx(CW_MSB, 0);  push_end(0, 0, 1, 64'h8000_0000_0000_0000);
        run_word("msb", 64'h8000_0000_0000_0000, 0, '0, M_DEC);
        push_tx(CW_2, 0);    push_end(0, 0, 1, 64'h2);
        run_word("two", 64'h2, 0, '0, M_DEC);
        push_tx(CW_ONES, 0); push_end(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_word("ones", 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, M_DEC);

        push_tx(72'h7, 0);   push_end(0, 0, 1, 64'h1);
        run_word("inj_single", 64'h1, 1, 72'h8, M_DEC);
        push_tx(72'h17, 0);  push_tx(CW_1, 1); push_end(0, 1, 1, 64'h1);
        run_word("inj_double", 64'h1, 1, 72'h18, M_DEC);

        for (int r = 0; r <= MAX_RETRY; r++) push_tx(CW_1, r);
        push_end(1, MAX_RETRY, 0, '0);
        run_word("always_resend", 64'h1, 0, '0, M_RESEND);

        for (int r = 0; r <= MAX_RETRY; r++) push_tx(CW_1, r);
        push_end(1, MAX_RETRY, 0, '0);
        run_word("silent", 64'h1, 0, '0, M_SILENT);

        push_tx(CW_1, 0);
        issue_word(64'h1, 0, '0, M_SILENT);
        repeat (3) @(negedge clk);
        check("wait_hold_codeword", 128'(codeword_out), 128'(CW_1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_codeword", 128'(codeword_out), 128'(0));
        check("midrst_sendin", 128'(sendin), 128'(0));
        check("midrst_retry_cnt", 128'(retry_cnt), 128'(0));
        check("midrst_done_fail", 128'({done, fail}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_ack", 128'(data_ack), 128'(1));
        repeat (40) @(negedge clk);

        push_tx(CW_MSB, 0);  push_end(0, 0, 1, 64'h8000_0000_0000_0000);
        run_word("after_reset", 64'h8000_0000_0000_0000, 0, '0, M_DEC);

        check("queues_drained", 128'(exp_tx.size() + exp_end.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
